// File: rtl/game_compositor.sv
// game_compositor: double-buffered game-state frame handoff synchronised to
// VGA vertical sync, frame/blink counters, and a per-pixel panel compositor
// with one cycle of output latency.
// Optional build macro: GAME_COMPOSITOR_PRIORITY_EN selects the colour of the
// lowest-index active panel instead of OR-ing the colours of all active panels.
module game_compositor #(
    parameter int NUM_PANELS   = 7,
    parameter int FRAME_BITS   = 200,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  v_sync,
    input  logic [FRAME_BITS-1:0] frame_in,
    input  logic                  frame_in_valid,
    output logic                  frame_in_ready,
    output logic [FRAME_BITS-1:0] frame_display,
    output logic                  frame_swap,
    output logic [15:0]           frame_count,
    output logic                  blink_phase,
    input  logic [NUM_PANELS-1:0] panel_hit,
    input  logic [NUM_PANELS-1:0] panel_R,
    input  logic [NUM_PANELS-1:0] panel_G,
    input  logic [NUM_PANELS-1:0] panel_B,
    input  logic [NUM_PANELS-1:0] panel_enable,
    input  logic [NUM_PANELS-1:0] panel_blink,
    output logic                  pixel_value_next_R,
    output logic                  pixel_value_next_G,
    output logic                  pixel_value_next_B
);

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic                  v_sync_reg;
    logic                  first_cycle_reg;
    logic                  sync_event;
    logic                  accept;
    logic [FRAME_BITS-1:0] pending_reg;
    logic                  pending_full_reg;
    logic [FRAME_BITS-1:0] frame_display_reg;
    logic                  frame_swap_reg;
    logic [15:0]           frame_count_reg;
    logic [7:0]            blink_cnt_reg;
    logic                  blink_phase_reg;
    logic [NUM_PANELS-1:0] panel_active;
    logic [2:0]            rgb_next;
    logic [2:0]            rgb_reg;

    // A sync event is the falling edge of v_sync; the cycle right after reset
    // is masked so a low v_sync at reset release cannot look like an edge.
    assign sync_event     = v_sync_reg & ~v_sync & ~first_cycle_reg;
    assign accept         = frame_in_valid & ~pending_full_reg;
    assign frame_in_ready = ~pending_full_reg;

    // Delay line for v_sync edge detection plus the post-reset mask flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_sync_reg      <= 1'b1;
            first_cycle_reg <= 1'b1;
        end else begin
            v_sync_reg      <= v_sync;
            first_cycle_reg <= 1'b0;
        end
    end

    // Pending/display double buffer: swap only on a sync event with a full
    // pending slot; an accept in the same cycle as an empty-slot sync waits
    // for the following sync.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_reg       <= '0;
            pending_full_reg  <= 1'b0;
            frame_display_reg <= '0;
            frame_swap_reg    <= 1'b0;
        end else begin
            frame_swap_reg <= 1'b0;
            if (sync_event && pending_full_reg) begin
                frame_display_reg <= pending_reg;
                pending_full_reg  <= 1'b0;
                frame_swap_reg    <= 1'b1;
            end
            if (accept) begin
                pending_reg      <= frame_in;
                pending_full_reg <= 1'b1;
            end
        end
    end

    // Frame counter and blink half-period counter, both advanced per sync.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count_reg <= '0;
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else if (sync_event) begin
            frame_count_reg <= frame_count_reg + 16'd1;
            if (blink_cnt_reg == BLINK_LAST) begin
                blink_cnt_reg   <= '0;
                blink_phase_reg <= ~blink_phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 8'd1;
            end
        end
    end

    // Per-panel activity: covered, enabled, and not hidden by the blink phase.
    generate
        for (genvar gi = 0; gi < NUM_PANELS; gi++) begin : g_active
            assign panel_active[gi] = panel_hit[gi] & panel_enable[gi]
                                      & ~(panel_blink[gi] & blink_phase_reg);
        end
    endgenerate

    // Colour selection across the active panels.
    always_comb begin
        rgb_next = 3'b000;
`ifdef GAME_COMPOSITOR_PRIORITY_EN
        // Walk downwards so the lowest-index active panel is written last.
        for (int i = NUM_PANELS - 1; i >= 0; i--) begin
            if (panel_active[i]) begin
                rgb_next = {panel_R[i], panel_G[i], panel_B[i]};
            end
        end
`else
        rgb_next = {|(panel_active & panel_R),
                    |(panel_active & panel_G),
                    |(panel_active & panel_B)};
`endif
    end

    // Output pixel register (one cycle latency from panel inputs).
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_reg <= 3'b000;
        end else begin
            rgb_reg <= rgb_next;
        end
    end

    assign frame_display      = frame_display_reg;
    assign frame_swap         = frame_swap_reg;
    assign frame_count        = frame_count_reg;
    assign blink_phase        = blink_phase_reg;
    assign pixel_value_next_R = rgb_reg[2];
    assign pixel_value_next_G = rgb_reg[1];
    assign pixel_value_next_B = rgb_reg[0];

endmodule

// File: tb/tb_game_compositor.sv
// Testbench for game_compositor: directed scenarios followed by random traffic,
// checked by a scoreboard fed from a behavioural model of the frame handoff,
// counters and compositor.
module tb_game_compositor;

    localparam int NP = 7;
    localparam int FB = 200;
    localparam int BF = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          v_sync;
    logic [FB-1:0] frame_in;
    logic          frame_in_valid;
    logic          frame_in_ready;
    logic [FB-1:0] frame_display;
    logic          frame_swap;
    logic [15:0]   frame_count;
    logic          blink_phase;
    logic [NP-1:0] panel_hit, panel_R, panel_G, panel_B, panel_enable, panel_blink;
    logic          pix_r, pix_g, pix_b;

    always #5 clk = ~clk;

    game_compositor #(
        .NUM_PANELS  (NP),
        .FRAME_BITS  (FB),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .v_sync            (v_sync),
        .frame_in          (frame_in),
        .frame_in_valid    (frame_in_valid),
        .frame_in_ready    (frame_in_ready),
        .frame_display     (frame_display),
        .frame_swap        (frame_swap),
        .frame_count       (frame_count),
        .blink_phase       (blink_phase),
        .panel_hit         (panel_hit),
        .panel_R           (panel_R),
        .panel_G           (panel_G),
        .panel_B           (panel_B),
        .panel_enable      (panel_enable),
        .panel_blink       (panel_blink),
        .pixel_value_next_R(pix_r),
        .pixel_value_next_G(pix_g),
        .pixel_value_next_B(pix_b)
    );

    typedef struct {
        logic [2:0]    rgb;
        logic          swap;
        logic [15:0]   cnt;
        logic          phase;
        logic          ready;
        logic [FB-1:0] disp;
    } exp_t;

    exp_t          exp_q[$];
    logic [FB-1:0] swap_q[$];

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic          m_prev_vs;
    logic          m_suppress;
    logic          m_pfull;
    logic [FB-1:0] m_pend;
    logic [FB-1:0] m_disp;
    int            m_syncs;

    function automatic logic [2:0] ref_pixel(input int phase);
        logic [2:0] acc;
        bit         found;
        bit         act;
        acc   = 3'b000;
        found = 0;
        for (int i = 0; i < NP; i++) begin
            act = panel_hit[i] && panel_enable[i] && !(panel_blink[i] && phase == 1);
`ifdef GAME_COMPOSITOR_PRIORITY_EN
            if (act && !found) begin
                acc   = {panel_R[i], panel_G[i], panel_B[i]};
                found = 1;
            end
`else
            if (act) begin
                acc   = acc | {panel_R[i], panel_G[i], panel_B[i]};
                found = 1;
            end
`endif
        end
        return acc;
    endfunction

    // Predict the outputs that follow the coming clock edge, then move on.
    task automatic tick();
        exp_t e;
        bit   sync;
        bit   acc;
        if (reset) begin
            m_prev_vs  = 1'b1;
            m_suppress = 1'b1;
            m_pfull    = 1'b0;
            m_pend     = '0;
            m_disp     = '0;
            m_syncs    = 0;
            e.rgb      = 3'b000;
            e.swap     = 1'b0;
        end else begin
            sync   = m_prev_vs && !v_sync && !m_suppress;
            acc    = frame_in_valid && !m_pfull;
            e.rgb  = ref_pixel((m_syncs / BF) % 2);
            e.swap = sync && m_pfull;
            if (e.swap) begin
                m_disp  = m_pend;
                m_pfull = 1'b0;
                swap_q.push_back(m_pend);
            end
            if (acc) begin
                m_pend  = frame_in;
                m_pfull = 1'b1;
            end
            if (sync) m_syncs++;
            m_prev_vs  = v_sync;
            m_suppress = 1'b0;
        end
        e.cnt   = 16'(m_syncs);
        e.phase = ((m_syncs / BF) % 2) == 1;
        e.ready = !m_pfull;
        e.disp  = m_disp;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic rand_frame();
        for (int k = 0; k < FB; k++) frame_in[k] = 1'($urandom_range(0, 1));
    endtask

    task automatic sync_pulse(input int high_cycles);
        v_sync = 1'b0;
        tick();
        v_sync = 1'b1;
        for (int k = 0; k < high_cycles; k++) tick();
    endtask

    // Monitor: compare every registered output just after each edge, and pop
    // the swap scoreboard whenever the DUT signals a swap.
    exp_t          mon_e;
    logic [FB-1:0] mon_f;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks += 6;
            if ({pix_r, pix_g, pix_b} !== mon_e.rgb) begin
                errors++;
                $display("FAIL pixel t=%0t got %b exp %b", $time, {pix_r, pix_g, pix_b}, mon_e.rgb);
            end
            if (frame_swap !== mon_e.swap) begin
                errors++;
                $display("FAIL frame_swap t=%0t got %b exp %b", $time, frame_swap, mon_e.swap);
            end
            if (frame_count !== mon_e.cnt) begin
                errors++;
                $display("FAIL frame_count t=%0t got %0d exp %0d", $time, frame_count, mon_e.cnt);
            end
            if (blink_phase !== mon_e.phase) begin
                errors++;
                $display("FAIL blink_phase t=%0t got %b exp %b", $time, blink_phase, mon_e.phase);
            end
            if (frame_in_ready !== mon_e.ready) begin
                errors++;
                $display("FAIL frame_in_ready t=%0t got %b exp %b", $time, frame_in_ready, mon_e.ready);
            end
            if (frame_display !== mon_e.disp) begin
                errors++;
                $display("FAIL frame_display t=%0t got %h exp %h", $time, frame_display, mon_e.disp);
            end
        end
        if (frame_swap === 1'b1) begin
            checks++;
            if (swap_q.size() == 0) begin
                errors++;
                $display("FAIL swap_unexpected t=%0t got swap exp none", $time);
            end else begin
                mon_f = swap_q.pop_front();
                if (frame_display !== mon_f) begin
                    errors++;
                    $display("FAIL swap_frame t=%0t got %h exp %h", $time, frame_display, mon_f);
                end
            end
        end
    end

    initial begin
        reset          = 1'b1;
        v_sync         = 1'b1;
        frame_in       = '0;
        frame_in_valid = 1'b0;
        panel_hit      = '0;
        panel_R        = '0;
        panel_G        = '0;
        panel_B        = '0;
        panel_enable   = '0;
        panel_blink    = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Basic swap: accept A, then falling v_sync
        rand_frame();
        frame_in_valid = 1'b1;
        tick();
        frame_in_valid = 1'b0;
        sync_pulse(3);

        // Backpressure: A accepted, B held off until the slot drains
        rand_frame();
        frame_in_valid = 1'b1;
        tick();
        rand_frame();
        for (int k = 0; k < 3; k++) tick();
        sync_pulse(1);
        frame_in_valid = 1'b0;
        sync_pulse(2);

        // Simultaneous accept and sync with empty slot
        tick();
        rand_frame();
        frame_in_valid = 1'b1;
        v_sync         = 1'b0;
        tick();
        frame_in_valid = 1'b0;
        v_sync         = 1'b1;
        tick();
        tick();
        sync_pulse(2);

        // Two-panel colour mix: panel 1 red only, panel 2 blue only
        panel_hit    = 7'b0000110;
        panel_enable = 7'b0000110;
        panel_R      = 7'b0000010;
        panel_B      = 7'b0000100;
        tick();
        tick();

        // Blink on panel 0
        reset = 1'b1;
        tick();
        reset        = 1'b0;
        panel_hit    = 7'b0000001;
        panel_enable = 7'b0000001;
        panel_blink  = 7'b0000001;
        panel_R      = 7'b0000001;
        panel_B      = 7'b0000000;
        tick();
        for (int k = 0; k < 8; k++) sync_pulse(3);

        // Reset mid-run with a full slot and frame_count=5
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) sync_pulse(2);
        rand_frame();
        frame_in_valid = 1'b1;
        tick();
        frame_in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        sync_pulse(2);

        // v_sync already low at reset release must not count as an edge
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        v_sync = 1'b0;
        tick();
        tick();
        v_sync = 1'b1;
        tick();

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            reset          = ($urandom_range(0, 299) == 0);
            v_sync         = ($urandom_range(0, 5) != 0);
            frame_in_valid = 1'($urandom_range(0, 1));
            rand_frame();
            panel_hit      = NP'($urandom);
            panel_R        = NP'($urandom);
            panel_G        = NP'($urandom);
            panel_B        = NP'($urandom);
            panel_enable   = NP'($urandom);
            panel_blink    = NP'($urandom);
            tick();
        end

        reset          = 1'b0;
        frame_in_valid = 1'b0;
        v_sync         = 1'b1;
        tick();
        tick();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL exp_queue_drain got %0d left exp 0", exp_q.size());
        end
        checks++;
        if (swap_q.size() != 0) begin
            errors++;
            $display("FAIL swap_queue_drain got %0d left exp 0", swap_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
